// File: rtl/dmem_port_arbiter_if.sv
// Two-master data-memory port bundle: master request/response lanes plus the dmem side.
interface dmem_port_arbiter_if #(
   parameter int unsigned DMEM_ADDR_WIDTH = 10
) ();
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic                       m0_req;
   logic                       m0_we;
   logic [DMEM_ADDR_WIDTH-1:0] m0_addr;
   logic [DW-1:0]              m0_wdata;
   logic [BW-1:0]              m0_be;
   logic                       m0_gnt;
   logic                       m0_done;
   logic [DW-1:0]              m0_rdata;

   logic                       m1_req;
   logic                       m1_we;
   logic [DMEM_ADDR_WIDTH-1:0] m1_addr;
   logic [DW-1:0]              m1_wdata;
   logic [BW-1:0]              m1_be;
   logic                       m1_gnt;
   logic                       m1_done;
   logic [DW-1:0]              m1_rdata;

   logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
   logic [DW-1:0]              dmem_din;
   logic                       dmem_mem_read;
   logic                       dmem_mem_write;
   logic [DW-1:0]              dmem_dout;
   logic                       busy;

   // Arbiter side
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      input  dmem_dout,
      output m0_gnt, m0_done, m0_rdata,
      output m1_gnt, m1_done, m1_rdata,
      output dmem_addr, dmem_din, dmem_mem_read, dmem_mem_write, busy
   );

   // Requester / memory side
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      output dmem_dout,
      input  m0_gnt, m0_done, m0_rdata,
      input  m1_gnt, m1_done, m1_rdata,
      input  dmem_addr, dmem_din, dmem_mem_read, dmem_mem_write, busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port dmem between two masters,
// with read-modify-write for partial byte-enable stores.
module dmem_port_arbiter #(
   parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 reset_b,
   dmem_port_arbiter_if.slave   bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

   state_t                     state_q, state_d;
   logic                       last_gnt_q, last_gnt_d;
   logic                       owner_q, owner_d;
   logic [DW-1:0]              wdata_q, wdata_d;
   logic [BW-1:0]              be_q, be_d;
   logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]              din_q, din_d;
   logic                       rd_q, rd_d;
   logic                       wr_q, wr_d;
   logic                       done0_q, done0_d;
   logic                       done1_q, done1_d;
   logic                       busy_q, busy_d;
   logic [DW-1:0]              rdata0_q, rdata0_d;
   logic [DW-1:0]              rdata1_q, rdata1_d;
   logic                       gnt0_c, gnt1_c;
   logic                       sel_we;
   logic [DMEM_ADDR_WIDTH-1:0] sel_addr;
   logic [DW-1:0]              sel_wdata;
   logic [BW-1:0]              sel_be;
   logic [DW-1:0]              merged_c;

   // Byte merge of latched store data over the current memory word
   always_comb begin
      merged_c = bus.dmem_dout;
      for (int i = 0; i < int'(BW); i++) begin
         if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state, grant and registered-output next values
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      addr_d     = addr_q;
      din_d      = din_q;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      gnt0_c     = 1'b0;
      gnt1_c     = 1'b0;
      sel_we     = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      sel_be     = '0;

      case (state_q)
         IDLE: begin
            // m0 wins when alone or when m1 was granted last
            if (reset_b) begin
               if (bus.m0_req && (!bus.m1_req || last_gnt_q)) gnt0_c = 1'b1;
               else if (bus.m1_req)                            gnt1_c = 1'b1;
            end
            sel_we    = gnt1_c ? bus.m1_we    : bus.m0_we;
            sel_addr  = gnt1_c ? bus.m1_addr  : bus.m0_addr;
            sel_wdata = gnt1_c ? bus.m1_wdata : bus.m0_wdata;
            sel_be    = gnt1_c ? bus.m1_be    : bus.m0_be;
            if (gnt0_c || gnt1_c) begin
               owner_d    = gnt1_c;
               last_gnt_d = gnt1_c;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               be_d       = sel_be;
               if (!sel_we) begin
                  state_d = RD;
                  rd_d    = 1'b1;
               end else if (sel_be == 4'hF || sel_be == 4'h0) begin
                  state_d = WR;
                  wr_d    = (sel_be == 4'hF);
                  din_d   = sel_wdata;
               end else begin
                  state_d = RMW_RD;
                  rd_d    = 1'b1;
               end
            end
         end
         RD: begin
            if (owner_q) rdata1_d = bus.dmem_dout;
            else         rdata0_d = bus.dmem_dout;
            done0_d = !owner_q;
            done1_d = owner_q;
            state_d = IDLE;
         end
         WR: begin
            done0_d = !owner_q;
            done1_d = owner_q;
            state_d = IDLE;
         end
         RMW_RD: begin
            din_d   = merged_c;
            wr_d    = 1'b1;
            state_d = RMW_WR;
         end
         RMW_WR: begin
            done0_d = !owner_q;
            done1_d = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and arbitration history
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Latched request payload and registered outputs
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         owner_q  <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         owner_q  <= owner_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign bus.m0_gnt         = gnt0_c;
   assign bus.m1_gnt         = gnt1_c;
   assign bus.m0_done        = done0_q;
   assign bus.m1_done        = done1_q;
   assign bus.m0_rdata       = rdata0_q;
   assign bus.m1_rdata       = rdata1_q;
   assign bus.dmem_addr      = addr_q;
   assign bus.dmem_din       = din_q;
   assign bus.dmem_mem_read  = rd_q;
   assign bus.dmem_mem_write = wr_q;
   assign bus.busy           = busy_q;
endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter DMEM_ADDR_WIDTH, default 10, SHALL set the dmem word-address width.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset_b  input  1  asynchronous active-low reset.
REQ-004 m0_req/m1_req  input  1  access request, held high until the matching gnt.
REQ-005 m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-006 m0_addr/m1_addr  input  DMEM_ADDR_WIDTH  word address.
REQ-007 m0_wdata/m1_wdata  input  32  write data.
REQ-008 m0_be/m1_be  input  4  write byte enables, bit i = byte i; ignored for reads.
REQ-009 m0_gnt/m1_gnt  output  1  one-cycle pulse; the request payload is sampled in this cycle.
REQ-010 m0_done/m1_done  output  1  one-cycle completion pulse.
REQ-011 m0_rdata/m1_rdata  output  32  read data, valid while the matching done is high after a read.
REQ-012 dmem_addr  output  DMEM_ADDR_WIDTH  address to the dmem.
REQ-013 dmem_din  output  32  write data to the dmem.
REQ-014 dmem_mem_read/dmem_mem_write  output  1  dmem strobes; the dmem writes on the clk edge while mem_write=1.
REQ-015 dmem_dout  input  32  dmem read data, combinational from dmem_addr.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, RD, WR, RMW_RD and RMW_WR.
REQ-018 Grants SHALL be issued only in IDLE, at most one per cycle, combinationally from req and the last_gnt register.
REQ-019 With one requester, that requester SHALL be granted; with both, the master not equal to last_gnt SHALL be granted, and last_gnt SHALL then update.
REQ-020 On a grant, the FSM SHALL latch master id, we, addr, wdata and be.
  - Next state SHALL be RD for a read, WR for be=1111 or be=0000, RMW_RD otherwise.
REQ-021 RD: dmem_mem_read=1, dmem_addr=latched addr; dmem_dout SHALL be registered into the owner's rdata; next state IDLE.
REQ-022 WR: dmem_mem_write=1 only when be=1111 (0 when be=0000), dmem_din=wdata; next state IDLE.
REQ-023 RMW_RD: dmem_mem_read=1; the FSM SHALL register the merged word (byte i = wdata byte i if be[i] else dout byte i); next state RMW_WR.
REQ-024 RMW_WR: dmem_mem_write=1, dmem_din=merged word; next state IDLE.
REQ-025 done SHALL pulse to the owner in the cycle after the final access state.
  - Latency from gnt cycle T: done at T+2 for RD/WR, T+3 for RMW.
REQ-026 done SHALL be concurrent with IDLE, so a new grant MAY occur in the same cycle as done.
REQ-027 rdata of each master SHALL hold its value until that master's next read completes; writes SHALL NOT modify rdata.
REQ-028 Strobes SHALL be 0, and dmem_addr/dmem_din SHALL hold their last value, in IDLE.
REQ-029 A req deasserted before its gnt SHALL be dropped with no side effect.

Reset
REQ-030 While reset_b=0: state=IDLE, last_gnt=1 (m0 wins the first tie), all gnt/done/strobes/busy=0, rdata=0, dmem_addr=0, dmem_din=0.
REQ-031 Reset asserted mid-transaction SHALL abort it: no dmem write after assertion, no done pulse.

Verification
REQ-032 m0 read of addr 5 holding 0xDEADBEEF: m0_gnt at T, mem_read at T+1, m0_done at T+2 with m0_rdata=0xDEADBEEF.
REQ-033 m1 write addr 3, wdata 0x11223344, be=1111: one mem_write at T+1, m1_done at T+2, dmem[3]=0x11223344.
REQ-034 dmem[7]=0xAABBCCDD, m0 write wdata 0x00000099 be=0001: RMW_RD at T+1, RMW_WR at T+2 with din=0xAABBCC99, done at T+3.
REQ-035 Both req held from reset release: grants alternate m0, m1, m0, m1; each new grant coincides with the prior done.
REQ-036 be=0000 write: no mem_write, done at T+2, memory unchanged.
REQ-037 reset_b low during RMW_RD: no mem_write, no done; all outputs match REQ-030.
